regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_wb_arbiter_pkg.sv | 26 ++
 rtl/regfile_wb_arbiter_if.sv | 27 ++
 rtl/regfile_wb_arbiter_rr_port_alloc.sv | 73 +++++++
 rtl/regfile_wb_arbiter.sv | 89 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and defaults for the regfile writeback arbiter.
// The payload structs are sized by the default index and data widths.
package rrd_pkg;

    localparam int unsigned num_req_def         = 4;
    localparam int unsigned num_write_ports_def = 3;
    localparam int unsigned s_index_def         = 5;
    localparam int unsigned s_width_def         = 32;

    typedef struct packed {
        logic [s_index_def-1:0] dest;
        logic [s_width_def-1:0] data;
    } wb_req_t;

    typedef struct packed {
        logic                   ld;
        logic [s_index_def-1:0] dest;
        logic [s_width_def-1:0] data;
    } wr_port_t;

    // Width of a requester index / round-robin pointer
    function automatic int unsigned ptr_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus plus the registered regfile write-port bus.
// The master side is the requester/regfile environment, the slave side is the arbiter.
interface regfile_wb_arbiter_if #(
    parameter int unsigned num_req         = rrd_pkg::num_req_def,
    parameter int unsigned num_write_ports = rrd_pkg::num_write_ports_def,
    parameter int unsigned s_index         = rrd_pkg::s_index_def,
    parameter int unsigned s_width         = rrd_pkg::s_width_def
);
    logic [num_req-1:0]         req_valid;
    logic [s_index-1:0]         req_dest [num_req];
    logic [s_width-1:0]         req_data [num_req];
    logic [num_req-1:0]         req_ready;
    logic [num_write_ports-1:0] wr_ld;
    logic [s_index-1:0]         wr_dest [num_write_ports];
    logic [s_width-1:0]         wr_data [num_write_ports];

    modport master (
        output req_valid, req_dest, req_data,
        input  req_ready, wr_ld, wr_dest, wr_data
    );

    modport slave (
        input  req_valid, req_dest, req_data,
        output req_ready, wr_ld, wr_dest, wr_data
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr_port_alloc.sv
// Rotating scan from rr_ptr that grants requests, packs nonzero-dest winners onto
// write ports in order, rejects duplicate destinations and computes the next pointer.
module rr_port_alloc
    import rrd_pkg::*;
#(
    parameter  int unsigned num_req         = num_req_def,
    parameter  int unsigned num_write_ports = num_write_ports_def,
    parameter  int unsigned s_index         = s_index_def,
    localparam int unsigned ptr_w           = ptr_bits(num_req)
) (
    input  logic [ptr_w-1:0]           rr_ptr,
    input  logic [num_req-1:0]         valid,
    input  logic [s_index-1:0]         dest [num_req],
    output logic [num_req-1:0]         grant,
    output logic [num_write_ports-1:0] port_used,
    output logic [ptr_w-1:0]           port_req [num_write_ports],
    output logic [ptr_w-1:0]           next_ptr
);

    logic [s_index-1:0] port_dest [num_write_ports];
    logic               conflict;
    logic               placed;
    int unsigned        slot;

    // Every index is a loop constant; the rotation is resolved by comparing against slot
    always_comb begin
        grant     = '0;
        port_used = '0;
        next_ptr  = rr_ptr;
        conflict  = 1'b0;
        placed    = 1'b0;
        slot      = 0;
        for (int unsigned p = 0; p < num_write_ports; p++) begin
            port_req[p]  = '0;
            port_dest[p] = '0;
        end

        for (int unsigned k = 0; k < num_req; k++) begin
            slot = (32'(rr_ptr) + k) % num_req;
            for (int unsigned i = 0; i < num_req; i++) begin
                if (i == slot && valid[i]) begin
                    if (dest[i] == '0) begin
                        // x0 writes are acknowledged and dropped without a port
                        grant[i] = 1'b1;
                    end else begin
                        conflict = 1'b0;
                        for (int unsigned p = 0; p < num_write_ports; p++) begin
                            if (port_used[p] && port_dest[p] == dest[i]) begin
                                conflict = 1'b1;
                            end
                        end
                        placed = 1'b0;
                        if (!conflict) begin
                            for (int unsigned p = 0; p < num_write_ports; p++) begin
                                if (!placed && !port_used[p]) begin
                                    port_used[p] = 1'b1;
                                    port_req[p]  = ptr_w'(i);
                                    port_dest[p] = dest[i];
                                    placed       = 1'b1;
                                end
                            end
                        end
                        if (placed) begin
                            grant[i] = 1'b1;
                            next_ptr = ptr_w'((i + 1) % num_req);
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the regfile write ports among writeback requesters;
// winners are registered onto the write ports one cycle after the grant.
module regfile_wb_arbiter
    import rrd_pkg::*;
#(
    parameter int unsigned num_req         = num_req_def,
    parameter int unsigned num_write_ports = num_write_ports_def,
    parameter int unsigned s_index         = s_index_def,
    parameter int unsigned s_width         = s_width_def
) (
    input logic                 clk,
    input logic                 rst,
    regfile_wb_arbiter_if.slave bus
);

    localparam int unsigned ptr_w = ptr_bits(num_req);

    logic [ptr_w-1:0]           rr_ptr;
    logic [ptr_w-1:0]           next_ptr;
    logic [num_req-1:0]         grant;
    logic [num_write_ports-1:0] port_used;
    logic [ptr_w-1:0]           port_req [num_write_ports];
    wb_req_t                    reqs     [num_req];
    wr_port_t                   wr_d     [num_write_ports];
    wr_port_t                   wr_q     [num_write_ports];

    always_comb begin
        for (int unsigned i = 0; i < num_req; i++) begin
            reqs[i].dest = s_index_def'(bus.req_dest[i]);
            reqs[i].data = s_width_def'(bus.req_data[i]);
        end
    end

    rr_port_alloc #(
        .num_req         (num_req),
        .num_write_ports (num_write_ports),
        .s_index         (s_index)
    ) u_alloc (
        .rr_ptr    (rr_ptr),
        .valid     (bus.req_valid),
        .dest      (bus.req_dest),
        .grant     (grant),
        .port_used (port_used),
        .port_req  (port_req),
        .next_ptr  (next_ptr)
    );

    assign bus.req_ready = grant;

    // Idle ports keep their last dest/data so the outputs stay deterministic
    always_comb begin
        for (int unsigned p = 0; p < num_write_ports; p++) begin
            wr_d[p]    = wr_q[p];
            wr_d[p].ld = 1'b0;
            if (port_used[p]) begin
                for (int unsigned i = 0; i < num_req; i++) begin
                    if (port_req[p] == ptr_w'(i)) begin
                        wr_d[p].ld   = 1'b1;
                        wr_d[p].dest = reqs[i].dest;
                        wr_d[p].data = reqs[i].data;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            for (int unsigned p = 0; p < num_write_ports; p++) begin
                wr_q[p] <= '0;
            end
        end else begin
            rr_ptr <= next_ptr;
            for (int unsigned p = 0; p < num_write_ports; p++) begin
                wr_q[p] <= wr_d[p];
            end
        end
    end

    always_comb begin
        for (int unsigned p = 0; p < num_write_ports; p++) begin
            bus.wr_ld[p]   = wr_q[p].ld;
            bus.wr_dest[p] = s_index'(wr_q[p].dest);
            bus.wr_data[p] = s_width'(wr_q[p].data);
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus randomized traffic, all
// checked against a transaction-level model of the round-robin write-port sharing.
module tb_regfile_wb_arbiter;

    localparam int unsigned num_req         = 4;
    localparam int unsigned num_write_ports = 3;
    localparam int unsigned s_index         = 5;
    localparam int unsigned s_width         = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(
        .num_req(num_req), .num_write_ports(num_write_ports),
        .s_index(s_index), .s_width(s_width)
    ) bus ();

    regfile_wb_arbiter #(
        .num_req(num_req), .num_write_ports(num_write_ports),
        .s_index(s_index), .s_width(s_width)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // requester state
    bit                 rv   [num_req];
    logic [s_index-1:0] rd   [num_req];
    logic [s_width-1:0] rdat [num_req];

    // reference model state
    int                 m_ptr;
    logic [num_req-1:0] m_ready;
    bit                 m_ld   [num_write_ports];
    logic [s_index-1:0] m_dest [num_write_ports];
    logic [s_width-1:0] m_data [num_write_ports];
    bit                 n_ld   [num_write_ports];
    logic [s_index-1:0] n_dest [num_write_ports];
    logic [s_width-1:0] n_data [num_write_ports];
    int                 n_ptr;

    logic [num_req-1:0] obs_ready;
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < num_req; i++) begin
            bus.req_valid[i] = rv[i];
            bus.req_dest[i]  = rd[i];
            bus.req_data[i]  = rdat[i];
        end
    endtask

    // Grants per the arbitration rules: visit requesters from the pointer onward,
    // a destination may be written once per cycle, ports fill from 0.
    task automatic model_arb();
        int used;
        int last;
        int idx;
        bit dup;
        logic [s_index-1:0] taken[$];
        used = 0;
        last = -1;
        m_ready = '0;
        for (int p = 0; p < num_write_ports; p++) begin
            n_ld[p]   = 1'b0;
            n_dest[p] = m_dest[p];
            n_data[p] = m_data[p];
        end
        for (int k = 0; k < num_req; k++) begin
            idx = (m_ptr + k) % num_req;
            dup = 1'b0;
            if (rv[idx]) begin
                if (rd[idx] == 0) begin
                    m_ready[idx] = 1'b1;
                end else begin
                    foreach (taken[j]) if (taken[j] == rd[idx]) dup = 1'b1;
                    if (!dup && used < num_write_ports) begin
                        m_ready[idx] = 1'b1;
                        n_ld[used]   = 1'b1;
                        n_dest[used] = rd[idx];
                        n_data[used] = rdat[idx];
                        used++;
                        last = idx;
                        taken.push_back(rd[idx]);
                    end
                end
            end
        end
        n_ptr = (last < 0) ? m_ptr : (last + 1) % num_req;
    endtask

    function automatic logic [127:0] got_ld();
        logic [127:0] v = '0;
        for (int p = 0; p < num_write_ports; p++) v[p] = bus.wr_ld[p];
        return v;
    endfunction

    function automatic logic [127:0] got_dest();
        logic [127:0] v = '0;
        for (int p = 0; p < num_write_ports; p++) v[p*s_index +: s_index] = bus.wr_dest[p];
        return v;
    endfunction

    function automatic logic [127:0] got_data();
        logic [127:0] v = '0;
        for (int p = 0; p < num_write_ports; p++) v[p*s_width +: s_width] = bus.wr_data[p];
        return v;
    endfunction

    // refill: 0 = retire granted requests, 1 = random new traffic, 2 = same dest, new data
    task automatic cycle(input bit r, input int refill);
        logic [127:0] e_ld, e_dest, e_data;
        logic [num_req-1:0] g;
        rst = r;
        drive();
        #1;
        model_arb();
        obs_ready = bus.req_ready;
        check("req_ready", obs_ready, m_ready);
        g = m_ready;
        @(posedge clk);
        #1;
        if (r) begin
            m_ptr = 0;
            for (int p = 0; p < num_write_ports; p++) begin
                m_ld[p] = 1'b0; m_dest[p] = '0; m_data[p] = '0;
            end
        end else begin
            m_ptr = n_ptr;
            for (int p = 0; p < num_write_ports; p++) begin
                m_ld[p] = n_ld[p]; m_dest[p] = n_dest[p]; m_data[p] = n_data[p];
            end
        end
        e_ld = '0; e_dest = '0; e_data = '0;
        for (int p = 0; p < num_write_ports; p++) begin
            e_ld[p] = m_ld[p];
            e_dest[p*s_index +: s_index] = m_dest[p];
            e_data[p*s_width +: s_width] = m_data[p];
        end
        check("wr_ld", got_ld(), e_ld);
        check("wr_dest", got_dest(), e_dest);
        check("wr_data", got_data(), e_data);
        if (!r) begin
            for (int i = 0; i < num_req; i++) begin
                if (refill == 1) begin
                    if (g[i] || !rv[i]) begin
                        rv[i]   = ($urandom_range(0, 3) != 0);
                        rd[i]   = s_index'($urandom_range(0, 7));
                        rdat[i] = $urandom;
                    end
                end else if (g[i]) begin
                    if (refill == 0) rv[i] = 1'b0;
                    else rdat[i] = $urandom;
                end
            end
        end
    endtask

    int gcnt [num_req];
    int wcnt [num_req];
    int wmax [num_req];

    initial begin
        for (int i = 0; i < num_req; i++) begin
            rv[i] = 1'b1; rd[i] = s_index'(i + 1); rdat[i] = 32'h1000 + 32'(i);
        end
        m_ptr = 0;
        for (int p = 0; p < num_write_ports; p++) begin
            m_ld[p] = 1'b0; m_dest[p] = '0; m_data[p] = '0;
        end
        rst = 1'b1;
        drive();
        @(posedge clk);
        #1;

        // reset held with every requester valid
        cycle(1'b1, 0);
        check("rst_wr_ld", got_ld(), 0);

        // capacity: three of four distinct dests granted, then the fourth
        cycle(1'b0, 0);
        check("cap_ready", obs_ready, 4'b0111);
        check("cap_wr_ld", got_ld(), 3'b111);
        check("cap_wr_dest", got_dest(), {5'd3, 5'd2, 5'd1});
        cycle(1'b0, 0);
        check("cap_ready_req3", obs_ready, 4'b1000);
        check("cap_port0_dest", 128'(bus.wr_dest[0]), 4);

        // same-destination conflict: req0 wins, req1 next cycle
        for (int i = 0; i < num_req; i++) rv[i] = 1'b0;
        rv[0] = 1'b1; rd[0] = 5'd5; rdat[0] = 32'hAAAA_0000;
        rv[1] = 1'b1; rd[1] = 5'd5; rdat[1] = 32'hBBBB_1111;
        cycle(1'b0, 0);
        check("conf_ready", obs_ready, 4'b0001);
        check("conf_data0", 128'(bus.wr_data[0]), 32'hAAAA_0000);
        cycle(1'b0, 0);
        check("conf_ready_req1", obs_ready, 4'b0010);
        check("conf_data1", 128'(bus.wr_data[0]), 32'hBBBB_1111);

        // x0 discard leaves pointer at 2, so req2 lands on port 0 afterwards
        rv[2] = 1'b1; rd[2] = 5'd0; rdat[2] = 32'hDEAD;
        cycle(1'b0, 0);
        check("x0_ready", obs_ready, 4'b0100);
        check("x0_wr_ld", got_ld(), 0);
        rv[1] = 1'b1; rd[1] = 5'd6; rdat[1] = 32'h66;
        rv[2] = 1'b1; rd[2] = 5'd7; rdat[2] = 32'h77;
        cycle(1'b0, 0);
        check("x0_ptr_port0", 128'(bus.wr_dest[0]), 7);

        // fairness: continuously valid, distinct dests
        for (int i = 0; i < num_req; i++) begin
            rv[i] = 1'b1; rd[i] = s_index'(i + 1); rdat[i] = $urandom;
            gcnt[i] = 0; wcnt[i] = 0; wmax[i] = 0;
        end
        for (int c = 0; c < 8; c++) begin
            cycle(1'b0, 2);
            for (int i = 0; i < num_req; i++) begin
                if (obs_ready[i]) begin
                    gcnt[i]++; wcnt[i] = 0;
                end else begin
                    wcnt[i]++;
                    if (wcnt[i] > wmax[i]) wmax[i] = wcnt[i];
                end
            end
        end
        for (int i = 0; i < num_req; i++) begin
            check("fair_count_ge6", 128'(gcnt[i] >= 6), 1);
            check("fair_wait_le2", 128'(wmax[i] <= 2), 1);
        end

        // mid-operation reset drops the registered grants
        cycle(1'b0, 2);
        check("mid_pre_ld", got_ld(), 3'b111);
        cycle(1'b1, 2);
        check("mid_rst_ld", got_ld(), 0);
        cycle(1'b0, 2);
        check("mid_post_ready", obs_ready, 4'b0111);

        // randomized traffic with small dest range and occasional reset
        for (int c = 0; c < 400; c++) begin
            cycle(($urandom_range(0, 49) == 0), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
